// File: rtl/mac_stream_driver.sv
// mac_stream_driver: length-prefixed multiply-accumulate front end.
// A start seeds the accumulator with a mode-selected bias. Each accepted
// (activation, weight) beat then adds one fixed-point product term.
// The finished sum is held on a valid/ready output until it is consumed.

// Single term: signed a*b, rescaled by the weight's fractional bits,
// truncated back to the accumulator width.
module mac_term #(
  parameter int DATA_W = 24,
  parameter int COEF_W = 16,
  parameter int FRAC_B = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [COEF_W-1:0] b,
  output logic [DATA_W-1:0] term
);
  localparam int PW = DATA_W + COEF_W;

  logic signed [PW-1:0] a_x, b_x, prod;

  // Sign-extend both operands to full product width so the multiply is exact
  assign a_x  = {{COEF_W{a[DATA_W-1]}}, a};
  assign b_x  = {{DATA_W{b[COEF_W-1]}}, b};
  assign prod = a_x * b_x;

  // Arithmetic shift keeps the sign; the low DATA_W bits are the term (wraps)
  assign term = DATA_W'(prod >>> FRAC_B);
endmodule

module mac_stream_driver #(
  parameter int DATA_W = 24,
  parameter int COEF_W = 16,
  parameter int FRAC_B = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              mode,
  input  logic [DATA_W-1:0] bias0,
  input  logic [DATA_W-1:0] bias1,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [COEF_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_mode,
  output logic              busy
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              mode_q;
  logic [DATA_W-1:0] term;
  logic              beat;
  logic              last_beat;

  mac_term #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .FRAC_B (FRAC_B)
  ) u_term (
    .a    (in_a),
    .b    (in_b),
    .term (term)
  );

  // A beat is an accepted term; in_ready is simply "in ACC".
  // cnt_q only reaches len-1 (<= 2^LEN_W-2), so it never wraps before the compare.
  assign beat      = (state_q == ACC) && in_valid;
  assign last_beat = beat && (cnt_q == (len_q - LEN_W'(1)));

  // Handshake outputs decode registered state only
  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = acc_q;
  assign out_mode  = mode_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: start only in IDLE, finish on last beat, drain on out_ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start)     state_d = (len == '0) ? DONE : ACC;
      ACC:  if (last_beat) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // Datapath: latch run parameters on start, accumulate on beats; acc_q
  // is untouched in DONE, so the result stays stable under backpressure
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          len_q  <= len;
          mode_q <= mode;
          acc_q  <= mode ? bias1 : bias0;
          cnt_q  <= '0;
        end
        ACC: if (beat) begin
          acc_q <= acc_q + term;
          cnt_q <= cnt_q + LEN_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_stream_driver.sv
// Bench for mac_stream_driver: directed cases plus randomized runs checked
// against an arithmetic model (bias + sum of rescaled products, mod 2^24).
module tb_mac_stream_driver;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        mode;
  logic [23:0] bias0, bias1;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic        out_mode;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] ta  [256];
  logic [15:0] tbw [256];

  mac_stream_driver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .mode      (mode),
    .bias0     (bias0),
    .bias1     (bias1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: seed with the chosen bias, add floor(a*b / 2^8) per term, keep 24 bits
  function automatic logic [23:0] model(input bit md, input int n,
                                        input logic [23:0] b0, input logic [23:0] b1);
    longint acc;
    longint p;
    acc = md ? longint'(b1) : longint'(b0);
    for (int i = 0; i < n; i++) begin
      p   = longint'($signed(ta[i])) * longint'($signed(tbw[i]));
      acc = acc + (p >>> 8);
    end
    return acc[23:0];
  endfunction

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      ta[i]  = 24'($urandom);
      tbw[i] = 16'($urandom);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full run from IDLE back to IDLE. Terms come from ta/tbw.
  // Called with the DUT in IDLE and the time 1 unit after a clock edge.
  task automatic run(input bit md, input int n, input logic [23:0] b0, input logic [23:0] b1,
                     input int gap, input int stall, input bit stray,
                     output logic [23:0] obs);
    logic [23:0] exp;
    exp = model(md, n, b0, b1);
    chk("idle_busy", busy, 0);
    start = 1'b1; len = 8'(n); mode = md; bias0 = b0; bias1 = b1;
    tick();
    // Scramble start-cycle inputs: they must no longer matter
    start = 1'b0; len = 8'($urandom); mode = 1'($urandom);
    bias0 = 24'($urandom); bias1 = 24'($urandom);
    chk("start_busy", busy, 1);
    chk("start_in_ready", in_ready, (n != 0));
    chk("start_out_valid", out_valid, (n == 0));
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0; in_a = 24'($urandom); in_b = 16'($urandom);
          out_ready = 1'($urandom);
          tick();
          chk("gap_in_ready", in_ready, 1);
          chk("gap_out_valid", out_valid, 0);
        end
      end
      in_valid = 1'b1; in_a = ta[i]; in_b = tbw[i]; out_ready = 1'($urandom);
      tick();
      in_valid = 1'b0; in_a = 24'($urandom); in_b = 16'($urandom); out_ready = 1'b0;
      chk("beat_out_valid", out_valid, (i == n - 1));
      chk("beat_in_ready", in_ready, (i != n - 1));
    end
    out_ready = 1'b0;
    chk("done_out_valid", out_valid, 1);
    chk("done_in_ready", in_ready, 0);
    chk("done_out_data", out_data, exp);
    chk("done_out_mode", out_mode, md);
    obs = out_data;
    for (int s = 0; s < stall; s++) begin
      start = stray && (s == 0);
      len   = 8'd3;
      tick();
      start = 1'b0;
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_data", out_data, exp);
      chk("stall_out_mode", out_mode, md);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drain_out_valid", out_valid, 0);
    chk("drain_busy", busy, 0);
  endtask

  initial begin
    logic [23:0] r1, r2, rr;
    bit          md;
    int          n;

    rst_n = 1'b0; start = 1'b0; len = '0; mode = 1'b0; bias0 = '0; bias1 = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_mode", out_mode, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Mode 0, three identical terms of 0x100 on a bias of 0x10
    for (int i = 0; i < 3; i++) begin ta[i] = 24'h000100; tbw[i] = 16'h0100; end
    run(1'b0, 3, 24'h000010, 24'h123456, 0, 0, 1'b0, rr);
    chk("m0_len3_data", rr, 24'h000310);

    // Mode 1, negative term (-256 * 2.0 = -512)
    ta[0] = 24'hFFFF00; tbw[0] = 16'h0200;
    run(1'b1, 1, 24'h999999, 24'h000020, 0, 0, 1'b0, rr);
    chk("m1_neg_data", rr, 24'hFFFE20);

    // Zero-length run returns the bias directly
    run(1'b0, 0, 24'h00ABCD, 24'h555555, 0, 2, 1'b0, rr);
    chk("len0_data", rr, 24'h00ABCD);

    // Backpressure: same terms gap-free and with gaps/stall/stray start
    fill_random(5);
    run(1'b0, 5, 24'h001234, 24'h0, 0, 0, 1'b0, r1);
    run(1'b0, 5, 24'h001234, 24'h0, 2, 5, 1'b1, r2);
    chk("bp_same_result", r2, r1);
    tick();
    chk("bp_no_stray_run", busy, 0);

    // Wrap: a term of +1 carries 0x7FFFFF into the sign bit
    ta[0] = 24'h000001; tbw[0] = 16'h0100;
    run(1'b0, 1, 24'h7FFFFF, 24'h0, 0, 0, 1'b0, rr);
    chk("wrap_data", rr, 24'h800000);

    // Reset after the 2nd of 4 beats, with random inputs during reset
    fill_random(4);
    start = 1'b1; len = 8'd4; mode = 1'b1; bias0 = 24'($urandom); bias1 = 24'($urandom);
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_a = ta[i]; in_b = tbw[i];
      tick();
    end
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'($urandom); start = 1'($urandom); out_ready = 1'($urandom);
      in_a = 24'($urandom); in_b = 16'($urandom); len = 8'($urandom); mode = 1'($urandom);
      tick();
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_out_data", out_data, 0);
      chk("midrst_out_mode", out_mode, 0);
    end
    rst_n = 1'b1; in_valid = 1'b0; start = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("postrst_out_valid", out_valid, 0);
      chk("postrst_busy", busy, 0);
    end
    run(1'b0, 4, 24'h000777, 24'h0, 0, 1, 1'b0, rr);

    // Randomized runs
    for (int r = 0; r < 10; r++) begin
      md = 1'($urandom);
      n  = int'($urandom_range(0, 12));
      fill_random(n);
      run(md, n, 24'($urandom), 24'($urandom), int'($urandom_range(0, 2)),
          int'($urandom_range(0, 3)), 1'($urandom), rr);
    end

    // Maximum length: the term counter must not wrap before the final compare
    fill_random(255);
    run(1'b1, 255, 24'($urandom), 24'($urandom), 0, 0, 1'b0, rr);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
